// File: rtl/step_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_gen
// Description : Step/direction pulse generator. Accepts a signed step count
//               and a step period, drives dir, waits a direction setup time,
//               then emits |steps| pulses of fixed high time at the requested
//               period. Supports a graceful abort that never truncates a
//               pulse already in progress.
// Revision    : 1.0 - initial release
// ============================================================================
module step_gen #(
    parameter int NBITS     = 16,
    parameter int PBITS     = 16,
    parameter int PULSE_W   = 4,
    parameter int DIR_SETUP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] steps,
    input  logic [PBITS-1:0] period,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] remaining
);

    // Counter must hold both PULSE_W-1 / low time (PBITS) and DIR_SETUP-1 (8 bits)
    localparam int CW = (PBITS > 8) ? PBITS : 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_HIGH   = 3'd2;
    localparam logic [2:0] S_LOW    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [PBITS-1:0] c_min_period = PBITS'(PULSE_W + 1);
    localparam logic [CW-1:0]    c_pulse_last = CW'(PULSE_W - 1);
    localparam logic [CW-1:0]    c_setup_last = CW'(DIR_SETUP - 1);
    localparam logic [NBITS-1:0] c_one        = {{(NBITS-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [PBITS-1:0] r_period;
    logic             r_abort;

    logic [NBITS-1:0] w_mag;
    logic [PBITS-1:0] w_eff_period;
    logic [CW-1:0]    w_low_last;
    logic             w_abort;

    // Unsigned magnitude of the request; the most negative value maps onto 2**(NBITS-1)
    assign w_mag        = steps[NBITS-1] ? ((~steps) + c_one) : steps;
    // Clamp period so the low phase is never shorter than one cycle
    assign w_eff_period = (period < c_min_period) ? c_min_period : period;
    // Low phase length minus one: effective period - PULSE_W - 1
    assign w_low_last   = CW'(r_period - c_min_period);
    // Abort seen now or earlier in this request
    assign w_abort      = abort | r_abort;

    // Request sequencing: accept, direction setup, pulse high/low, finish strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_abort   <= 1'b0;
            step      <= 1'b0;
            dir       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!busy) begin
                        // Accepting cycle: abort here is deliberately ignored
                        if (start) begin
                            remaining <= w_mag;
                            dir       <= steps[NBITS-1];
                            r_period  <= w_eff_period;
                            r_abort   <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end else begin
                        // Load cycle following acceptance: choose setup or empty finish
                        r_abort <= w_abort;
                        if (remaining == '0) begin
                            r_state <= S_FINISH;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_SETUP;
                            r_cnt   <= c_setup_last;
                        end
                    end
                end

                S_SETUP: begin
                    r_abort <= w_abort;
                    if (w_abort) begin
                        r_state <= S_FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_state   <= S_HIGH;
                        step      <= 1'b1;
                        remaining <= remaining - c_one;
                        r_cnt     <= c_pulse_last;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_HIGH: begin
                    // High time always runs to completion, abort is only remembered
                    r_abort <= w_abort;
                    if (r_cnt == '0) begin
                        r_state <= S_LOW;
                        step    <= 1'b0;
                        r_cnt   <= w_low_last;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_LOW: begin
                    r_abort <= w_abort;
                    if (r_cnt == '0) begin
                        if ((remaining != '0) && !w_abort) begin
                            r_state   <= S_HIGH;
                            step      <= 1'b1;
                            remaining <= remaining - c_one;
                            r_cnt     <= c_pulse_last;
                        end else begin
                            r_state <= S_FINISH;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_FINISH: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    step    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/step_gen.md
STEP_GEN -- requirements
Module: step_gen

Interface
REQ-001 Parameter NBITS, default 16: width of the signed step request and of the remaining-steps count.
REQ-002 Parameter PBITS, default 16: width of the step period, in clk cycles.
REQ-003 Parameter PULSE_W, default 4: step high time in clk cycles, range 1..2**PBITS-2.
REQ-004 Parameter DIR_SETUP, default 2: clk cycles between dir update and the first step rising edge, range 1..255.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  request strobe; sampled only in IDLE.
REQ-008 steps  input  NBITS  signed step request, two's complement; sign gives direction.
REQ-009 period  input  PBITS  clk cycles from one step rising edge to the next.
REQ-010 abort  input  1  stop request; no further pulses start after the current one.
REQ-011 step  output  1  step pulse, registered.
REQ-012 dir  output  1  direction: 1 = negative request, 0 = positive or zero request; registered.
REQ-013 busy  output  1  high while a request is in progress.
REQ-014 done  output  1  one-cycle strobe marking the end of a request.
REQ-015 remaining  output  NBITS  unsigned count of pulses not yet started.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, HIGH, LOW and FINISH.
REQ-017 In IDLE with start=1, the block SHALL latch the magnitude |steps| into remaining, set dir to the sign bit of steps, latch the effective period, assert busy, and enter SETUP on the next edge.
REQ-018 The magnitude SHALL be computed unsigned at NBITS width, so steps = -2**(NBITS-1) yields remaining = 2**(NBITS-1).
REQ-019 The effective period SHALL be max(period, PULSE_W+1), fixing the minimum low time at 1 clk cycle.
REQ-020 If the latched magnitude is 0, the block SHALL skip SETUP and enter FINISH, emitting no pulse.
REQ-021 SETUP SHALL last exactly DIR_SETUP cycles, then enter HIGH.
REQ-022 On entry to HIGH, step SHALL rise and remaining SHALL decrement by 1 in the same cycle.
REQ-023 step SHALL stay high for exactly PULSE_W cycles, then LOW SHALL hold step low for (effective period - PULSE_W) cycles.
REQ-024 At the end of LOW, the block SHALL re-enter HIGH if remaining > 0 and abort has not been latched; otherwise it SHALL enter FINISH.
REQ-025 FINISH SHALL last 1 cycle with done=1, then return to IDLE; busy SHALL fall in the same cycle that done rises.
REQ-026 abort=1 in any non-IDLE cycle SHALL be latched; a step high time already started SHALL never be truncated.
REQ-027 An abort latched in SETUP SHALL send the block to FINISH with no pulse.
REQ-028 After an abort, remaining SHALL hold the count of pulses never started.
REQ-029 start SHALL be ignored while busy=1, including in the FINISH cycle.
REQ-030 steps and period SHALL be ignored outside the accepting IDLE cycle.
REQ-031 abort in IDLE SHALL have no effect.
REQ-032 If start and abort are both 1 in the accepting IDLE cycle, the request SHALL be accepted and abort SHALL be ignored.
REQ-033 dir SHALL hold its value from the accepting cycle until the next accepted request.

Reset
REQ-034 With rst=1 at a clk edge, the block SHALL enter IDLE and set step=0, dir=0, busy=0, done=0 and remaining=0, and clear the abort latch and the period latch.
REQ-035 rst SHALL take priority over every other input and may abort a request mid-pulse, truncating step.
REQ-036 After rst is released, the block SHALL accept start on the first following cycle.

Verification
REQ-037 steps=3, period=10, defaults -> dir=0; first step rise 2 cycles after SETUP entry; 3 pulses, each 4 cycles high, rises 10 cycles apart; remaining 3->2->1->0; done one cycle after the last LOW ends.
REQ-038 steps=-2, period=2 -> dir=1; effective period 5; pulses 4 cycles high and 1 cycle low; remaining ends at 0.
REQ-039 steps=0 -> no pulse; done=1 two cycles after start; busy high for exactly 1 cycle.
REQ-040 steps=5, period=10, abort pulsed 1 cycle during the 2nd pulse's HIGH -> exactly 2 full 4-cycle pulses; done asserted; remaining=3.
REQ-041 start pulsed again mid-request with steps=7 -> ignored; original count completes; then steps=-32768 accepted with remaining=32768 and dir=1.
REQ-042 rst asserted during the HIGH of pulse 1 -> next cycle step=0, busy=0, done=0, remaining=0; new start accepted on the cycle after rst deasserts.
